sd_block_io: RTL and testbench
==============================

SD_BLOCK_IO -- requirements
Module: sd_block_io

Interface
REQ-001 Parameter CLK_DIV, default 4: SCLK half-period in clk cycles (legal 2..255).
REQ-002 clk  input  1  system clock; all logic on posedge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 read_spi  input  1  one-cycle request: read block into sector buffer.
REQ-005 write_spi  input  1  one-cycle request: write sector buffer to block.
REQ-006 block  input  23  block number, sampled with the request.
REQ-007 busy  output  1  transfer in progress.
REQ-008 error  output  1  last transfer failed; sticky.
REQ-009 buf_addr  output  9  sector buffer byte address.
REQ-010 buf_wdata  output  8  byte written to buffer.
REQ-011 buf_we  output  1  buffer write strobe.
REQ-012 buf_rdata  input  8  buffer read data, one-cycle latency after buf_addr.
REQ-013 sd_cs  output  1  card chip select, active low.
REQ-014 sd_sclk  output  1  SPI clock.
REQ-015 sd_mosi  output  1  SPI data out.
REQ-016 sd_miso  input  1  SPI data in.

Function
REQ-017 Card is in SPI mode, initialized and block-addressed; initialization is out of scope.
REQ-018 Request accepted at a posedge where busy=0 and read_spi or write_spi=1; busy=1 and block latched at that same edge.
REQ-019 read_spi and write_spi both high: write wins. Requests while busy=1 ignored.
REQ-020 Accept clears error.
REQ-021 SPI mode 0: sclk idles low; mosi changes on falling edge; miso sampled on rising edge; MSB first; idle mosi=1.
REQ-022 States: IDLE, CMD, RESP, RD_TOKEN, RD_DATA, RD_CRC, WR_TOKEN, WR_DATA, WR_CRC, WR_RESP, WR_BUSY, FINISH.
REQ-023 IDLE->CMD on accept; sd_cs low from first CMD byte until FINISH.
REQ-024 CMD: six bytes: 0x51 (read) or 0x58 (write), argument {9'b0, block} MSB first, then 0xFF.
REQ-025 RESP: clock 0xFF bytes until byte != 0xFF, max 8 bytes; R1=0x00 -> RD_TOKEN or WR_TOKEN; R1!=0x00 or 8 x 0xFF -> error, FINISH.
REQ-026 RD_TOKEN: poll until 0xFE, max 65535 bytes; other non-0xFF byte or timeout -> error, FINISH.
REQ-027 RD_DATA: 512 bytes; byte n written with buf_addr=n, buf_we one cycle; n=0..511 in order.
REQ-028 RD_CRC: two bytes discarded -> FINISH.
REQ-029 WR_TOKEN: send 0xFF then 0xFE.
REQ-030 WR_DATA: send buffer bytes 0..511; buf_addr presented at least one cycle before byte load.
REQ-031 WR_CRC: send 0xFF, 0xFF.
REQ-032 WR_RESP: read one byte; (byte & 0x1F)==0x05 -> WR_BUSY, else error, FINISH.
REQ-033 WR_BUSY: poll until 0xFF, max 65535 bytes; timeout -> error.
REQ-034 FINISH: sd_cs high, send one 0xFF byte, then busy=0 and IDLE; error valid when busy falls.
REQ-035 buf_we never asserted outside RD_DATA; byte counter 10 bits, no wrap past 511.

Reset
REQ-036 On rst: state IDLE, busy=0, error=0, sd_cs=1, sd_sclk=0, sd_mosi=1, buf_we=0, buf_addr=0, buf_wdata=0, counters 0.
REQ-037 rst mid-transfer aborts immediately; no buffer write after rst; next request starts from CMD.

Structure
REQ-038 Command opcodes, tokens (0xFE), R1/data-response masks, timeout limits and state encodings live in shared package sd_pkg.
REQ-039 Sub-module sd_spi_byte: start/tx_byte in, rx_byte/done out, full-duplex byte with CLK_DIV timing; owns sd_sclk, sd_mosi.

Verification
REQ-040 Read block 0x000123, card model R1=0x00, two 0xFF then 0xFE, data n^0x5A -> cmd bytes 51 00 00 01 23 FF; buffer[n]=n^0x5A; busy falls; error=0.
REQ-041 Write block 0x7FFFFF, buffer[n]=n -> cmd 58 00 7F FF FF FF; card receives FE, 00..FF twice; response 0xE5; three busy 0x00 bytes; error=0.
REQ-042 Read with R1=0x04 -> error=1, zero buf_we pulses, sd_cs high, busy=0.
REQ-043 Card never sends token (all 0xFF) -> error=1 after 65535 poll bytes; busy=0.
REQ-044 read_spi and write_spi same cycle -> write performed; second read_spi during busy ignored.
REQ-045 rst asserted at RD_DATA byte 100 -> outputs at reset values same cycle; next read completes correctly.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared constants, state encoding and helpers for the SD card SPI block-transfer engine.
// The card is assumed initialized and block-addressed; only CMD17/CMD24 are issued.
package sd_pkg;

    localparam logic [7:0] CMD_READ     = 8'h51;  // CMD17, READ_SINGLE_BLOCK
    localparam logic [7:0] CMD_WRITE    = 8'h58;  // CMD24, WRITE_BLOCK
    localparam logic [7:0] TOKEN_START  = 8'hFE;
    localparam logic [7:0] IDLE_BYTE    = 8'hFF;
    localparam logic [7:0] R1_OK        = 8'h00;
    localparam logic [7:0] DRESP_MASK   = 8'h1F;
    localparam logic [7:0] DRESP_ACCEPT = 8'h05;

    localparam int unsigned CMD_LEN     = 6;
    localparam int unsigned RESP_MAX    = 8;
    localparam int unsigned POLL_MAX    = 65535;
    localparam int unsigned BLOCK_BYTES = 512;

    typedef enum logic [3:0] {
        IDLE,
        CMD,
        RESP,
        RD_TOKEN,
        RD_DATA,
        RD_CRC,
        WR_TOKEN,
        WR_DATA,
        WR_CRC,
        WR_RESP,
        WR_BUSY,
        FINISH
    } sd_state_e;

    // All controller state kept in one record so the FSM can be written as cur -> nxt.
    typedef struct packed {
        sd_state_e   state;
        logic        busy;
        logic        error;
        logic        cs_n;
        logic        is_write;
        logic        in_flight;
        logic [22:0] blk;
        logic [9:0]  byte_cnt;
        logic [15:0] poll_cnt;
        logic [8:0]  buf_addr;
        logic [7:0]  buf_wdata;
        logic        buf_we;
    } ctrl_t;

    function automatic ctrl_t ctrl_reset();
        ctrl_t r;
        r           = '0;
        r.state     = IDLE;
        r.cs_n      = 1'b1;
        return r;
    endfunction

    // Byte idx of the six-byte command frame: opcode, 32-bit block argument, dummy CRC.
    function automatic logic [7:0] cmd_byte(input logic [2:0] idx,
                                            input logic       is_write,
                                            input logic [22:0] blk);
        logic [31:0] arg;
        arg = {9'b0, blk};
        case (idx)
            3'd0:    return is_write ? CMD_WRITE : CMD_READ;
            3'd1:    return arg[31:24];
            3'd2:    return arg[23:16];
            3'd3:    return arg[15:8];
            3'd4:    return arg[7:0];
            default: return IDLE_BYTE;
        endcase
    endfunction

endpackage

// File: rtl/sd_spi_byte.sv
// Full-duplex SPI mode-0 byte shifter: MSB first, SCLK half-period of CLK_DIV clk cycles.
// done pulses for one cycle after the eighth falling edge; rx_byte is valid from then on.
module sd_spi_byte #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    output logic [7:0] rx_byte,
    output logic       done,
    output logic       sd_sclk,
    output logic       sd_mosi,
    input  logic       sd_miso
);

    logic       active;
    logic [7:0] div_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] tx_sr;
    logic [7:0] rx_sr;

    // NOTE: every register here uses <= so all updates see pre-edge values, whatever the order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active  <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            done    <= 1'b0;
            sd_sclk <= 1'b0;
            sd_mosi <= 1'b1;
        end else begin
            done <= 1'b0;
            if (!active) begin
                if (start) begin
                    // First bit must be on the line before the first rising edge.
                    active  <= 1'b1;
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    sd_mosi <= tx_byte[7];
                    tx_sr   <= {tx_byte[6:0], 1'b0};
                end
            end else if (div_cnt == 8'(CLK_DIV - 1)) begin
                div_cnt <= '0;
                if (!sd_sclk) begin
                    sd_sclk <= 1'b1;
                    rx_sr   <= {rx_sr[6:0], sd_miso};
                end else begin
                    sd_sclk <= 1'b0;
                    if (bit_cnt == 3'd7) begin
                        active  <= 1'b0;
                        done    <= 1'b1;
                        sd_mosi <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                        sd_mosi <= tx_sr[7];
                        tx_sr   <= {tx_sr[6:0], 1'b0};
                    end
                end
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end
        end
    end

    assign rx_byte = rx_sr;

endmodule

// File: rtl/sd_block_io.sv
// Single-block SD read/write over SPI between the card and a 512-byte sector buffer.
// One byte is in flight at a time; the FSM decides what to send next when it completes.
module sd_block_io
    import sd_pkg::*;
#(
    parameter int          CLK_DIV    = 4,
    parameter int unsigned POLL_LIMIT = POLL_MAX
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_spi,
    input  logic        write_spi,
    input  logic [22:0] block,
    output logic        busy,
    output logic        error,
    output logic [8:0]  buf_addr,
    output logic [7:0]  buf_wdata,
    output logic        buf_we,
    input  logic [7:0]  buf_rdata,
    output logic        sd_cs,
    output logic        sd_sclk,
    output logic        sd_mosi,
    input  logic        sd_miso
);

    ctrl_t      cur;
    ctrl_t      nxt;
    logic       spi_start;
    logic [7:0] spi_tx;
    logic [7:0] spi_rx;
    logic       spi_done;

    sd_spi_byte #(
        .CLK_DIV (CLK_DIV)
    ) u_spi (
        .clk     (clk),
        .rst     (rst),
        .start   (spi_start),
        .tx_byte (spi_tx),
        .rx_byte (spi_rx),
        .done    (spi_done),
        .sd_sclk (sd_sclk),
        .sd_mosi (sd_mosi),
        .sd_miso (sd_miso)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cur <= ctrl_reset();
        else     cur <= nxt;
    end

    // NOTE: nxt and the SPI controls get defaults first so no path through the case leaves a latch.
    always_comb begin
        nxt        = cur;
        nxt.buf_we = 1'b0;
        spi_start  = 1'b0;
        spi_tx     = IDLE_BYTE;

        if (cur.state != IDLE && !cur.in_flight) begin
            spi_start     = 1'b1;
            nxt.in_flight = 1'b1;
        end
        if (spi_done) nxt.in_flight = 1'b0;

        unique case (cur.state)
            IDLE: begin
                if (read_spi || write_spi) begin
                    nxt.state    = CMD;
                    nxt.busy     = 1'b1;
                    nxt.error    = 1'b0;
                    nxt.cs_n     = 1'b0;
                    nxt.is_write = write_spi;
                    nxt.blk      = block;
                    nxt.byte_cnt = '0;
                    nxt.poll_cnt = '0;
                    nxt.buf_addr = '0;
                end
            end

            CMD: begin
                spi_tx = cmd_byte(cur.byte_cnt[2:0], cur.is_write, cur.blk);
                if (spi_done) begin
                    if (cur.byte_cnt == 10'(CMD_LEN - 1)) begin
                        nxt.state    = RESP;
                        nxt.byte_cnt = '0;
                        nxt.poll_cnt = '0;
                    end else begin
                        nxt.byte_cnt = cur.byte_cnt + 10'd1;
                    end
                end
            end

            RESP: begin
                if (spi_done) begin
                    if (spi_rx == R1_OK) begin
                        nxt.state    = cur.is_write ? WR_TOKEN : RD_TOKEN;
                        nxt.poll_cnt = '0;
                        nxt.byte_cnt = '0;
                    end else if (spi_rx != IDLE_BYTE || cur.poll_cnt == 16'(RESP_MAX - 1)) begin
                        nxt.state = FINISH;
                        nxt.error = 1'b1;
                    end else begin
                        nxt.poll_cnt = cur.poll_cnt + 16'd1;
                    end
                end
            end

            RD_TOKEN: begin
                if (spi_done) begin
                    if (spi_rx == TOKEN_START) begin
                        nxt.state    = RD_DATA;
                        nxt.byte_cnt = '0;
                    end else if (spi_rx != IDLE_BYTE || cur.poll_cnt == 16'(POLL_LIMIT - 1)) begin
                        nxt.state = FINISH;
                        nxt.error = 1'b1;
                    end else begin
                        nxt.poll_cnt = cur.poll_cnt + 16'd1;
                    end
                end
            end

            RD_DATA: begin
                if (spi_done) begin
                    nxt.buf_we    = 1'b1;
                    nxt.buf_addr  = cur.byte_cnt[8:0];
                    nxt.buf_wdata = spi_rx;
                    if (cur.byte_cnt == 10'(BLOCK_BYTES - 1)) begin
                        nxt.state    = RD_CRC;
                        nxt.byte_cnt = '0;
                    end else begin
                        nxt.byte_cnt = cur.byte_cnt + 10'd1;
                    end
                end
            end

            RD_CRC: begin
                if (spi_done) begin
                    if (cur.byte_cnt == 10'd1) nxt.state = FINISH;
                    else                       nxt.byte_cnt = cur.byte_cnt + 10'd1;
                end
            end

            WR_TOKEN: begin
                spi_tx = (cur.byte_cnt == 10'd0) ? IDLE_BYTE : TOKEN_START;
                if (spi_done) begin
                    if (cur.byte_cnt == 10'd1) begin
                        nxt.state    = WR_DATA;
                        nxt.byte_cnt = '0;
                    end else begin
                        nxt.byte_cnt = cur.byte_cnt + 10'd1;
                    end
                end
            end

            WR_DATA: begin
                // buf_addr already points at this byte; step it to prefetch the next one.
                spi_tx = buf_rdata;
                if (spi_start && cur.byte_cnt != 10'(BLOCK_BYTES - 1))
                    nxt.buf_addr = cur.byte_cnt[8:0] + 9'd1;
                if (spi_done) begin
                    if (cur.byte_cnt == 10'(BLOCK_BYTES - 1)) begin
                        nxt.state    = WR_CRC;
                        nxt.byte_cnt = '0;
                    end else begin
                        nxt.byte_cnt = cur.byte_cnt + 10'd1;
                    end
                end
            end

            WR_CRC: begin
                if (spi_done) begin
                    if (cur.byte_cnt == 10'd1) nxt.state = WR_RESP;
                    else                       nxt.byte_cnt = cur.byte_cnt + 10'd1;
                end
            end

            WR_RESP: begin
                if (spi_done) begin
                    if ((spi_rx & DRESP_MASK) == DRESP_ACCEPT) begin
                        nxt.state    = WR_BUSY;
                        nxt.poll_cnt = '0;
                    end else begin
                        nxt.state = FINISH;
                        nxt.error = 1'b1;
                    end
                end
            end

            WR_BUSY: begin
                if (spi_done) begin
                    if (spi_rx == IDLE_BYTE) begin
                        nxt.state = FINISH;
                    end else if (cur.poll_cnt == 16'(POLL_LIMIT - 1)) begin
                        nxt.state = FINISH;
                        nxt.error = 1'b1;
                    end else begin
                        nxt.poll_cnt = cur.poll_cnt + 16'd1;
                    end
                end
            end

            FINISH: begin
                if (spi_done) begin
                    nxt.state = IDLE;
                    nxt.busy  = 1'b0;
                end
            end

            default: nxt.state = IDLE;
        endcase

        // The trailing 0xFF byte is clocked with the card deselected.
        if (nxt.state == FINISH) nxt.cs_n = 1'b1;
    end

    assign busy      = cur.busy;
    assign error     = cur.error;
    assign sd_cs     = cur.cs_n;
    assign buf_addr  = cur.buf_addr;
    assign buf_wdata = cur.buf_wdata;
    assign buf_we    = cur.buf_we;

endmodule

// File: tb/tb_sd_block_io.sv
// Directed bench for sd_block_io: scripted SPI card model plus registered sector buffer.
// The card answers by byte index since chip-select fell, according to the current mode.
module tb_sd_block_io;

    localparam int          CLK_DIV    = 2;
    localparam int unsigned POLL_LIMIT = 20;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        read_spi  = 1'b0;
    logic        write_spi = 1'b0;
    logic [22:0] block     = '0;
    logic        busy;
    logic        error;
    logic [8:0]  buf_addr;
    logic [7:0]  buf_wdata;
    logic        buf_we;
    logic [7:0]  buf_rdata = '0;
    logic        sd_cs;
    logic        sd_sclk;
    logic        sd_mosi;
    logic        sd_miso   = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sd_block_io #(
        .CLK_DIV    (CLK_DIV),
        .POLL_LIMIT (POLL_LIMIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .read_spi  (read_spi),
        .write_spi (write_spi),
        .block     (block),
        .busy      (busy),
        .error     (error),
        .buf_addr  (buf_addr),
        .buf_wdata (buf_wdata),
        .buf_we    (buf_we),
        .buf_rdata (buf_rdata),
        .sd_cs     (sd_cs),
        .sd_sclk   (sd_sclk),
        .sd_mosi   (sd_mosi),
        .sd_miso   (sd_miso)
    );

    // Sector buffer with one-cycle read latency; fill_go loads buffer[n] = n.
    logic [7:0] mem [0:511];
    logic       fill_go  = 1'b0;
    int         we_count = 0;

    always @(posedge clk) begin
        if (fill_go) begin
            for (int i = 0; i < 512; i++) mem[i] <= 8'(i);
        end else if (buf_we) begin
            mem[buf_addr] <= buf_wdata;
        end
        buf_rdata <= mem[buf_addr];
        if (buf_we) we_count <= we_count + 1;
    end

    typedef enum int {M_RD_OK, M_RD_R1ERR, M_NO_TOKEN, M_WR_OK} card_mode_e;

    card_mode_e mode = M_RD_OK;
    logic [7:0] key  = 8'h5A;
    logic [7:0] rx_log [0:1023];
    int         c_idx = 0;
    int         c_bit = 0;
    logic [7:0] c_in  = '0;
    logic [7:0] c_out = 8'hFF;
    logic       prev_cs   = 1'b1;
    logic       prev_sclk = 1'b0;

    // Read: idx 0-5 cmd, 6 R1, 7-8 0xFF, 9 token, 10-521 data, 522-523 CRC.
    // Write: idx 6 R1, 7-8 token, 9-520 data, 521-522 CRC, 523 response, 524-526 busy.
    function automatic logic [7:0] card_out(input int idx);
        case (mode)
            M_RD_OK: begin
                if (idx == 6)                  return 8'h00;
                if (idx == 9)                  return 8'hFE;
                if (idx >= 10 && idx < 522)    return 8'(idx - 10) ^ key;
                return 8'hFF;
            end
            M_RD_R1ERR: return (idx == 6) ? 8'h04 : 8'hFF;
            M_NO_TOKEN: return (idx == 6) ? 8'h00 : 8'hFF;
            default: begin
                if (idx == 6)                  return 8'h00;
                if (idx == 523)                return 8'hE5;
                if (idx >= 524 && idx <= 526)  return 8'h00;
                return 8'hFF;
            end
        endcase
    endfunction

    always @(sd_cs or sd_sclk) begin
        if (prev_cs && !sd_cs) begin
            c_idx   = 0;
            c_bit   = 0;
            c_out   = card_out(0);
            sd_miso = c_out[7];
        end else if (!sd_cs && !prev_sclk && sd_sclk) begin
            c_in  = {c_in[6:0], sd_mosi};
            c_bit = c_bit + 1;
            if (c_bit == 8) begin
                if (c_idx < 1024) rx_log[c_idx] = c_in;
                c_idx = c_idx + 1;
                c_bit = 0;
                c_out = card_out(c_idx);
            end
        end else if (!sd_cs && prev_sclk && !sd_sclk) begin
            sd_miso = c_out[3'(7 - c_bit)];
        end
        prev_cs   = sd_cs;
        prev_sclk = sd_sclk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check(tag, 64'({busy, error, sd_cs, sd_sclk, sd_mosi, buf_we, buf_addr, buf_wdata}),
              64'({1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 9'd0, 8'd0}));
    endtask

    task automatic request(input logic rd, input logic wr, input logic [22:0] blk);
        @(negedge clk);
        read_spi  = rd;
        write_spi = wr;
        block     = blk;
        @(negedge clk);
        read_spi  = 1'b0;
        write_spi = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(busy), 64'(0));
    endtask

    function automatic logic [47:0] cmd_bytes();
        return {rx_log[0], rx_log[1], rx_log[2], rx_log[3], rx_log[4], rx_log[5]};
    endfunction

    task automatic check_buffer(input string tag, input logic [7:0] k);
        int bad = 0;
        for (int n = 0; n < 512; n++)
            if (mem[n] !== (8'(n) ^ k)) bad++;
        check(tag, 64'(bad), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int we_base;
        int bad;
        int n;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("reset_state");
        rst = 1'b0;
        @(negedge clk);

        // Normal read of block 0x000123.
        mode    = M_RD_OK;
        key     = 8'h5A;
        we_base = we_count;
        request(1'b1, 1'b0, 23'h000123);
        check("rd_busy", 64'(busy), 64'(1));
        check("rd_cs_low", 64'(sd_cs), 64'(0));
        wait_idle(25000, "rd_done");
        check("rd_cmd", 64'(cmd_bytes()), 64'(48'h51_00_00_01_23_FF));
        check("rd_byte_count", 64'(c_idx), 64'(524));
        check("rd_we_pulses", 64'(we_count - we_base), 64'(512));
        check_buffer("rd_buffer", 8'h5A);
        check("rd_error", 64'(error), 64'(0));
        check("rd_idle_lines", 64'({sd_cs, sd_sclk, sd_mosi}), 64'(3'b101));

        // Write of block 0x7FFFFF with simultaneous read/write request and an ignored read.
        @(negedge clk);
        fill_go = 1'b1;
        @(negedge clk);
        fill_go = 1'b0;
        mode    = M_WR_OK;
        we_base = we_count;
        request(1'b1, 1'b1, 23'h7FFFFF);
        check("wr_busy", 64'(busy), 64'(1));
        repeat (20) @(negedge clk);
        read_spi = 1'b1;
        block    = 23'h000042;
        @(negedge clk);
        read_spi = 1'b0;
        wait_idle(25000, "wr_done");
        check("wr_cmd", 64'(cmd_bytes()), 64'(48'h58_00_7F_FF_FF_FF));
        check("wr_token", 64'({rx_log[7], rx_log[8]}), 64'(16'hFFFE));
        bad = 0;
        for (int i = 0; i < 512; i++)
            if (rx_log[9 + i] !== 8'(i)) bad++;
        check("wr_data", 64'(bad), 64'(0));
        check("wr_crc", 64'({rx_log[521], rx_log[522]}), 64'(16'hFFFF));
        check("wr_byte_count", 64'(c_idx), 64'(528));
        check("wr_no_buf_we", 64'(we_count - we_base), 64'(0));
        check("wr_error", 64'(error), 64'(0));
        repeat (200) @(negedge clk);
        check("wr_second_read_ignored", 64'({busy, sd_cs}), 64'(2'b01));

        // R1 reports an error: no data phase.
        mode    = M_RD_R1ERR;
        we_base = we_count;
        request(1'b1, 1'b0, 23'h000010);
        wait_idle(5000, "r1_done");
        check("r1_error", 64'(error), 64'(1));
        check("r1_no_buf_we", 64'(we_count - we_base), 64'(0));
        check("r1_byte_count", 64'(c_idx), 64'(7));
        check("r1_cs_high", 64'(sd_cs), 64'(1));

        // Card never sends a start token: times out after POLL_LIMIT poll bytes.
        mode    = M_NO_TOKEN;
        we_base = we_count;
        request(1'b1, 1'b0, 23'h000020);
        check("nt_error_cleared_on_accept", 64'(error), 64'(0));
        wait_idle(5000, "nt_done");
        check("nt_error", 64'(error), 64'(1));
        check("nt_byte_count", 64'(c_idx), 64'(7 + POLL_LIMIT));
        check("nt_no_buf_we", 64'(we_count - we_base), 64'(0));

        // Reset during the data phase of a read, then a clean read.
        mode    = M_RD_OK;
        key     = 8'hC3;
        we_base = we_count;
        request(1'b1, 1'b0, 23'h000005);
        n = 0;
        while ((we_count - we_base) < 100 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("abort_reach_byte100", 64'(we_count - we_base), 64'(100));
        rst = 1'b1;
        #1;
        check_reset("abort_reset_same_cycle");
        repeat (5) @(negedge clk);
        check("abort_no_write_after_rst", 64'(we_count - we_base), 64'(100));
        rst = 1'b0;
        @(negedge clk);

        key     = 8'h3C;
        we_base = we_count;
        request(1'b1, 1'b0, 23'h456789);
        wait_idle(25000, "rerd_done");
        check("rerd_cmd", 64'(cmd_bytes()), 64'(48'h51_00_45_67_89_FF));
        check("rerd_we_pulses", 64'(we_count - we_base), 64'(512));
        check_buffer("rerd_buffer", 8'h3C);
        check("rerd_error", 64'(error), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
